// File: rtl/sweep_collector_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_collector_pkg: register map, constants and FIFO entry layout.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package sweep_collector_pkg;

  localparam logic [2:0] REG_ID     = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_FIFO   = 3'd2;
  localparam logic [2:0] REG_DROP   = 3'd3;
  localparam logic [2:0] REG_MASK   = 3'd4;
  localparam logic [2:0] REG_CTRL   = 3'd5;
  localparam logic [2:0] REG_TS     = 3'd6;

  localparam logic [31:0] ID_VALUE   = 32'h5C01_0010;
  localparam logic [31:0] EMPTY_MARK = 32'hDEAD_BEEF;

  localparam int SENSOR_LSB = 28;
  localparam int LH_BIT     = 27;
  localparam int AXIS_BIT   = 26;

`ifdef SWEEP_COLLECTOR_TIMESTAMP_EN
  localparam int FIFO_W = 64;
`else
  localparam int FIFO_W = 32;
`endif

  function automatic logic [31:0] pack_entry(input logic [3:0] idx, input logic lh,
                                             input logic axis, input logic [25:0] dur);
    logic [31:0] e;
    e = '0;
    e[SENSOR_LSB +: 4]  = idx;
    e[LH_BIT]           = lh;
    e[AXIS_BIT]         = axis;
    e[AXIS_BIT-1:0]     = dur;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_collector_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_collector_if: Avalon-MM slave bus bundle for the sweep collector.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface sweep_collector_if;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (output address, write, writedata, read, input readdata, waitrequest);
  modport slave  (input address, write, writedata, read, output readdata, waitrequest);
endinterface
`default_nettype wire

// File: rtl/sweep_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_fifo: synchronous first-word-fall-through FIFO with flush.         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module sweep_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     i_push,
  input  wire logic [WIDTH-1:0]         i_data,
  input  wire logic                     i_pop,
  input  wire logic                     i_flush,
  output logic      [WIDTH-1:0]         o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_fill_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // flush overrides both push and pop so the FIFO always ends empty
  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_full       = (r_count == (AW+1)'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign o_fill_count = r_count;
endmodule
`default_nettype wire

// File: rtl/sweep_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_collector: per-sensor edge capture, round-robin arbiter, FIFO,     |
// | Avalon-MM register slave. Option: SWEEP_COLLECTOR_TIMESTAMP_EN.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module sweep_collector
  import sweep_collector_pkg::*;
#(
  parameter int NUM_SENSORS = 16,
  parameter int DUR_W       = 26,
  parameter int FIFO_DEPTH  = 64
) (
  input  wire logic                         clock,
  input  wire logic                         reset,
  input  wire logic [NUM_SENSORS-1:0]       i_sensor_valid,
  input  wire logic [NUM_SENSORS-1:0]       i_sensor_lighthouse_id,
  input  wire logic [NUM_SENSORS-1:0]       i_sensor_axis,
  input  wire logic [NUM_SENSORS*DUR_W-1:0] i_sensor_duration,
  sweep_collector_if.slave                  bus,
  output logic                              o_irq
);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SENSORS-1:0]   r_valid_q, r_pending, r_mask, r_hold_lh, r_hold_axis;
  logic [DUR_W-1:0]         r_hold_dur [NUM_SENSORS];
  logic [3:0]               r_rr_ptr;
  logic [31:0]              r_drop_count;
  logic                     r_irq;

  logic [NUM_SENSORS-1:0]   w_edge, w_mask_clr, w_cap, w_drop, w_grant_oh, w_rot;
  logic [2*NUM_SENSORS-1:0] w_dbl;
  logic                     w_flush, w_clr_drop, w_mask_wr, w_pop, w_grant_valid;
  logic [3:0]               w_grant;
  logic [4:0]               w_sum;
  logic [32:0]              w_drop_sum;
  logic [FIFO_W-1:0]        w_fifo_in, w_fifo_head;
  logic                     w_full, w_empty;
  logic [FW-1:0]            w_fill;
  logic                     w_unused;

  assign w_mask_wr  = bus.write && (bus.address == REG_MASK);
  assign w_flush    = bus.write && (bus.address == REG_CTRL) && bus.writedata[0];
  assign w_clr_drop = bus.write && (bus.address == REG_CTRL) && bus.writedata[1];
  assign w_mask_clr = w_mask_wr ? ~bus.writedata[NUM_SENSORS-1:0] : '0;
  assign w_pop      = bus.read && (bus.address == REG_FIFO);
  assign w_unused   = ^bus.writedata;

  assign w_edge = i_sensor_valid & ~r_valid_q;
  assign w_cap  = w_flush ? '0 : (w_edge & r_mask & ~w_mask_clr);

  // rotate pending so bit 0 is rr_ptr, then take the first set bit
  assign w_dbl = {r_pending, r_pending} >> r_rr_ptr;
  assign w_rot = w_dbl[NUM_SENSORS-1:0];

  always_comb begin
    w_grant_valid = 1'b0;
    w_sum         = '0;
    for (int k = NUM_SENSORS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_grant_valid = 1'b1;
        w_sum         = {1'b0, r_rr_ptr} + 5'(k);
      end
    end
    if (w_sum >= 5'(NUM_SENSORS)) w_sum = w_sum - 5'(NUM_SENSORS);
    if (w_full || w_flush) w_grant_valid = 1'b0;
  end

  assign w_grant    = w_sum[3:0];
  assign w_grant_oh = w_grant_valid ? (NUM_SENSORS'(1) << w_grant) : '0;
  // a sensor granted this cycle frees its slot, so a same-cycle edge is not a drop
  assign w_drop     = w_cap & r_pending & ~w_grant_oh;
  assign w_drop_sum = {1'b0, r_drop_count} + 33'($countones(w_drop));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid_q    <= '0;
      r_pending    <= '0;
      r_mask       <= '1;
      r_rr_ptr     <= '0;
      r_drop_count <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_valid_q <= i_sensor_valid;
      r_irq     <= ~w_empty;
      if (w_flush) r_pending <= '0;
      else         r_pending <= ((r_pending & ~w_grant_oh) | w_cap) & ~w_mask_clr;
      if (w_mask_wr) r_mask <= bus.writedata[NUM_SENSORS-1:0];
      if (w_grant_valid)
        r_rr_ptr <= (w_grant == 4'(NUM_SENSORS - 1)) ? 4'd0 : w_grant + 4'd1;
      if (w_clr_drop)         r_drop_count <= '0;
      else if (w_drop_sum[32]) r_drop_count <= '1;
      else                    r_drop_count <= w_drop_sum[31:0];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (w_cap[i]) begin
        r_hold_lh[i]   <= i_sensor_lighthouse_id[i];
        r_hold_axis[i] <= i_sensor_axis[i];
        r_hold_dur[i]  <= i_sensor_duration[i*DUR_W +: DUR_W];
      end
    end
  end

`ifdef SWEEP_COLLECTOR_TIMESTAMP_EN
  logic [31:0] r_cycle;
  logic [31:0] r_hold_ts [NUM_SENSORS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_cycle <= '0;
    else       r_cycle <= r_cycle + 32'd1;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SENSORS; i++)
      if (w_cap[i]) r_hold_ts[i] <= r_cycle;
  end

  assign w_fifo_in = {r_hold_ts[w_grant],
                      pack_entry(w_grant, r_hold_lh[w_grant], r_hold_axis[w_grant],
                                 26'(r_hold_dur[w_grant]))};
`else
  assign w_fifo_in = pack_entry(w_grant, r_hold_lh[w_grant], r_hold_axis[w_grant],
                                26'(r_hold_dur[w_grant]));
`endif

  sweep_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .i_push       (w_grant_valid),
    .i_data       (w_fifo_in),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .o_head       (w_fifo_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_fill_count (w_fill)
  );

  always_comb begin
    bus.readdata = EMPTY_MARK;
    case (bus.address)
      REG_ID:     bus.readdata = ID_VALUE;
      REG_STATUS: bus.readdata = {16'(w_fill), 14'b0, w_full, w_empty};
      REG_FIFO:   if (!w_empty) bus.readdata = w_fifo_head[31:0];
      REG_DROP:   bus.readdata = r_drop_count;
      REG_MASK:   bus.readdata = 32'(r_mask);
`ifdef SWEEP_COLLECTOR_TIMESTAMP_EN
      REG_TS:     if (!w_empty) bus.readdata = w_fifo_head[63:32];
`else
      REG_TS:     bus.readdata = EMPTY_MARK;
`endif
      default:    bus.readdata = EMPTY_MARK;
    endcase
  end

  assign bus.waitrequest = 1'b0;
  assign o_irq           = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_sweep_collector.sv
`default_nettype none
// Bench for sweep_collector: directed scenarios with literal expectations plus
// randomized traffic, every cycle compared against a queue-based reference model.
module tb_sweep_collector;
  localparam int N     = 16;
  localparam int DW    = 26;
  localparam int DEPTH = 64;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    lh    = '0;
  logic [N-1:0]    ax    = '0;
  logic [N*DW-1:0] dur   = '0;
  logic            irq;

  int n_checks = 0;
  int n_pass   = 0;

  sweep_collector_if bus();

  sweep_collector #(.NUM_SENSORS(N), .DUR_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .i_sensor_valid         (valid),
    .i_sensor_lighthouse_id (lh),
    .i_sensor_axis          (ax),
    .i_sensor_duration      (dur),
    .bus                    (bus),
    .o_irq                  (irq)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [31:0] q[$];
  logic [31:0] m_hold [N];
  logic [N-1:0] m_pend, m_mask, m_vprev;
  int          m_rr;
  logic [31:0] m_drop;
  logic        m_irq;

  task automatic model_step();
    logic [N-1:0] edges, clr, cap;
    bit flush, clrdrop, mwr;
    int g, d;
    longint t;
    edges   = valid & ~m_vprev;
    m_vprev = valid;
    mwr     = bus.write && bus.address == 3'd4;
    flush   = bus.write && bus.address == 3'd5 && bus.writedata[0];
    clrdrop = bus.write && bus.address == 3'd5 && bus.writedata[1];
    clr     = mwr ? ~bus.writedata[N-1:0] : '0;
    m_irq   = (q.size() != 0);
    g = -1;
    d = 0;
    if (!flush && q.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_rr + k) % N;
        if (m_pend[s]) begin g = s; break; end
      end
    end
    if (flush) begin
      q.delete();
      m_pend = '0;
    end else begin
      if (bus.read && bus.address == 3'd2 && q.size() != 0) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back(m_hold[g]);
        m_pend[g] = 1'b0;
        m_rr = (g + 1) % N;
      end
      cap = edges & m_mask & ~clr;
      for (int i = 0; i < N; i++) begin
        if (cap[i]) begin
          if (m_pend[i]) d++;
          m_hold[i] = {4'(i), lh[i], ax[i], dur[i*DW +: DW]};
          m_pend[i] = 1'b1;
        end
      end
      m_pend = m_pend & ~clr;
    end
    if (mwr) m_mask = bus.writedata[N-1:0];
    t = longint'(m_drop) + longint'(d);
    if (clrdrop)                 m_drop = '0;
    else if (t > 64'hFFFF_FFFF)  m_drop = '1;
    else                         m_drop = t[31:0];
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_pend  = '0;
      m_mask  = '1;
      m_vprev = '0;
      m_rr    = 0;
      m_drop  = '0;
      m_irq   = 1'b0;
    end else begin
      model_step();
    end
  end

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'h5C01_0010;
      3'd1:    return {16'(q.size()), 14'b0, q.size() == DEPTH, q.size() == 0};
      3'd2:    return (q.size() != 0) ? q[0] : 32'hDEAD_BEEF;
      3'd3:    return m_drop;
      3'd4:    return {16'b0, m_mask};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // per-cycle compare against the model
  always @(negedge clock) begin
    if (!reset) begin
      check("irq", 32'(irq), 32'(m_irq));
      check("waitrequest", 32'(bus.waitrequest), 32'd0);
`ifdef SWEEP_COLLECTOR_TIMESTAMP_EN
      if (bus.address != 3'd6)
`endif
      check("readdata", bus.readdata, model_read(bus.address));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address = a; bus.read = 1'b1;
    #2 d = bus.readdata;
    @(posedge clock); #1;
    bus.read = 1'b0; bus.address = 3'd0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(posedge clock); #1;
    bus.write = 1'b0; bus.address = 3'd0; bus.writedata = '0;
  endtask

  task automatic set_sensor(input int s, input logic l, input logic a, input logic [DW-1:0] d);
    lh[s] = l; ax[s] = a; dur[s*DW +: DW] = d;
  endtask

  task automatic fire(input logic [N-1:0] bits);
    valid = valid | bits;
    tick(1);
    valid = valid & ~bits;
  endtask

  task automatic rand_all();
    for (int s = 0; s < N; s++) set_sensor(s, 1'($urandom), 1'($urandom), DW'($urandom));
  endtask

  logic [31:0] rv;

  initial begin
    bus.address = 3'd0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    tick(1);

    // reset state
    rd(3'd1, rv); check("reset_status", rv, 32'h0000_0001);
    rd(3'd4, rv); check("reset_mask", rv, 32'h0000_FFFF);
    rd(3'd3, rv); check("reset_drop", rv, 32'h0000_0000);
    rd(3'd0, rv); check("id", rv, 32'h5C01_0010);
    rd(3'd2, rv); check("empty_pop", rv, 32'hDEAD_BEEF);

    // single event, two-cycle latency
    set_sensor(3, 1'b1, 1'b0, 26'h12345);
    fire(16'h0008);
    tick(1);
    rd(3'd1, rv); check("single_status", rv, 32'h0001_0000);
    rd(3'd2, rv); check("single_entry", rv, 32'h3801_2345);
    rd(3'd1, rv); check("single_drained", rv, 32'h0000_0001);

    // align rr_ptr to 0, then same-cycle burst on 0,5,15
    rand_all();
    fire(16'h8000); tick(2); rd(3'd2, rv);
    check("align_idx", 32'(rv[31:28]), 32'd15);
    fire(16'h8021); tick(4);
    rd(3'd2, rv); check("burst1_a", 32'(rv[31:28]), 32'd0);
    rd(3'd2, rv); check("burst1_b", 32'(rv[31:28]), 32'd5);
    rd(3'd2, rv); check("burst1_c", 32'(rv[31:28]), 32'd15);
    fire(16'h0001); tick(2); rd(3'd2, rv);
    check("align0_idx", 32'(rv[31:28]), 32'd0);
    fire(16'h8021); tick(4);
    rd(3'd2, rv); check("burst2_a", 32'(rv[31:28]), 32'd5);
    rd(3'd2, rv); check("burst2_b", 32'(rv[31:28]), 32'd15);
    rd(3'd2, rv); check("burst2_c", 32'(rv[31:28]), 32'd0);

    // fill to 64, overwrite a pending sensor while full
    for (int r = 0; r < 4; r++) begin rand_all(); fire(16'hFFFF); tick(17); end
    rd(3'd1, rv); check("full_status", rv, 32'h0040_0002);
    set_sensor(2, 1'b0, 1'b1, 26'h000AAAA); fire(16'h0004); tick(1);
    set_sensor(2, 1'b1, 1'b1, 26'h000BBBB); fire(16'h0004); tick(1);
    rd(3'd3, rv); check("full_drop", rv, 32'd1);
    rd(3'd2, rv); tick(2);
    rd(3'd1, rv); check("full_refill", rv, 32'h0040_0002);
    for (int r = 0; r < 64; r++) rd(3'd2, rv);
    check("full_last", rv, 32'h2C00_BBBB);
    rd(3'd1, rv); check("full_drained", rv, 32'h0000_0001);

    // enable mask
    wr(3'd4, 32'h0000_0001);
    rand_all(); fire(16'h0003); tick(3);
    rd(3'd1, rv); check("mask_status", rv, 32'h0001_0000);
    rd(3'd2, rv); check("mask_idx", 32'(rv[31:28]), 32'd0);
    wr(3'd4, 32'h0000_FFFF);

    // flush and drop clear
    rand_all(); fire(16'hFFFF); tick(1); fire(16'h8000); tick(8);
    rd(3'd3, rv); check("pre_flush_drop", rv, 32'd2);
    wr(3'd5, 32'h0000_0003);
    check("irq_before_fall", 32'(irq), 32'd1);
    tick(1);
    check("irq_fell", 32'(irq), 32'd0);
    rd(3'd1, rv); check("flush_status", rv, 32'h0000_0001);
    rd(3'd3, rv); check("flush_drop", rv, 32'd0);
    tick(20);
    rd(3'd1, rv); check("flush_no_pending", rv, 32'h0000_0001);

    // asynchronous reset mid-burst
    rand_all(); fire(16'hFFFF); tick(3);
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    @(posedge clock); #1;
    rd(3'd1, rv); check("rst_status", rv, 32'h0000_0001);
    rd(3'd4, rv); check("rst_mask", rv, 32'h0000_FFFF);
    rd(3'd2, rv); check("rst_pop", rv, 32'hDEAD_BEEF);
    rd(3'd3, rv); check("rst_drop", rv, 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r, rp;
      logic [2:0] a;
      rp = (c < 1500) ? 85 : 30;
      for (int s = 0; s < N; s++) begin
        if (valid[s]) begin
          if ($urandom_range(1, 0) == 1) valid[s] = 1'b0;
        end else if ($urandom_range(7, 0) == 0) begin
          set_sensor(s, 1'($urandom), 1'($urandom), DW'($urandom));
          valid[s] = 1'b1;
        end
      end
      bus.read = 1'b0; bus.write = 1'b0; bus.address = 3'd0; bus.writedata = '0;
      r = $urandom_range(99, 0);
      if (r < rp - 10) begin
        bus.read = 1'b1; bus.address = 3'd2;
      end else if (r < rp) begin
        bus.read = 1'b1; bus.address = 3'($urandom);
      end else if (r < rp + 3) begin
        bus.write = 1'b1; bus.address = 3'd4;
        bus.writedata = 32'($urandom) | 32'(16'($urandom));
      end else if (r == rp + 3) begin
        bus.write = 1'b1; bus.address = 3'd5; bus.writedata = 32'($urandom_range(3, 0));
      end else if (r < rp + 6) begin
        a = 3'($urandom);
        if (a == 3'd4 || a == 3'd5) a = 3'd7;
        bus.write = 1'b1; bus.address = a; bus.writedata = $urandom;
      end
      @(posedge clock); #1;
    end
    bus.read = 1'b0; bus.write = 1'b0;
    valid = '0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
